// File: rtl/console_writer_pkg.sv
// Shared display defines (buffer geometry, address widths, control codes) and
// the types used by the console writer and its cursor unit.
`ifndef DISPLAY_DEFINES_SV
`define DISPLAY_DEFINES_SV

`define DP_X_ADDR_WIDTH 7
`define DP_Y_ADDR_WIDTH 5
`define DP_REG_WIDTH    16
`define DP_COLS         80
`define DP_ROWS         30

`define DP_CHAR_BS      8'h08
`define DP_CHAR_LF      8'h0A
`define DP_CHAR_FF      8'h0C
`define DP_CHAR_CR      8'h0D

package console_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCROLL,
        ST_CLEAR
    } state_t;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADV,
        CUR_CR,
        CUR_LF,
        CUR_BS,
        CUR_HOME
    } cur_op_t;

    localparam logic [7:0] SPACE = 8'h20;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

`endif

// File: rtl/console_cursor.sv
// Cursor register with advance/wrap/backspace arithmetic; flags when a row
// increment would run off the bottom so the writer can scroll instead.
module console_cursor
    import console_writer_pkg::*;
#(
    parameter int COLS = `DP_COLS,
    parameter int ROWS = `DP_ROWS
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  cur_op_t                     op,
    output logic [`DP_X_ADDR_WIDTH-1:0] x,
    output logic [`DP_Y_ADDR_WIDTH-1:0] y,
    output logic                        scroll_req
);
    localparam int XW = `DP_X_ADDR_WIDTH;
    localparam int YW = `DP_Y_ADDR_WIDTH;
    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    logic [XW-1:0] x_nx;
    logic [YW-1:0] y_nx;
    logic          wrap;

    always_comb begin
        x_nx = x;
        y_nx = y;
        wrap = 1'b0;
        case (op)
            CUR_ADV: begin
                if (x == X_LAST) begin
                    x_nx = '0;
                    wrap = 1'b1;
                end else begin
                    x_nx = x + 1'b1;
                end
            end
            CUR_CR:   x_nx = '0;
            CUR_LF: begin
                x_nx = '0;
                wrap = 1'b1;
            end
            CUR_BS:   if (x != '0) x_nx = x - 1'b1;
            CUR_HOME: begin
                x_nx = '0;
                y_nx = '0;
            end
            default: ;
        endcase
        // On the last row the cursor stays put; the scroll makes room instead.
        scroll_req = wrap && (y == Y_LAST);
        if (wrap && !scroll_req) y_nx = y + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_nx;
            y <= y_nx;
        end
    end

endmodule

// File: rtl/console_writer.sv
// Byte-stream console: writes printable characters into a text buffer,
// handles CR/LF/BS/FF, and scrolls the buffer up one row when needed.
module console_writer
    import console_writer_pkg::*;
#(
    parameter int COLS = `DP_COLS,
    parameter int ROWS = `DP_ROWS
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  in_char,
    input  logic [7:0]                  in_attr,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        wr_en,
    output logic [`DP_X_ADDR_WIDTH-1:0] wr_x,
    output logic [`DP_Y_ADDR_WIDTH-1:0] wr_y,
    output logic [15:0]                 wr_data,
    output logic [`DP_X_ADDR_WIDTH-1:0] rd_x,
    output logic [`DP_Y_ADDR_WIDTH-1:0] rd_y,
    input  logic [15:0]                 rd_data,
    output logic [`DP_REG_WIDTH-1:0]    ctrl_reg
);
    localparam int XW = `DP_X_ADDR_WIDTH;
    localparam int YW = `DP_Y_ADDR_WIDTH;
    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    state_t        state, state_nx;
    cur_op_t       op;
    logic [XW-1:0] cur_x, cnt_x, wr_x_q, cp_x;
    logic [YW-1:0] cur_y, cnt_y, wr_y_q, cp_y;
    logic          scroll_req, accept, filling;
    logic          wr_en_q, cp_vld;
    logic [15:0]   wr_data_q;
    logic [7:0]    attr_q;

    console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .x          (cur_x),
        .y          (cur_y),
        .scroll_req (scroll_req)
    );

    assign in_ready = reset_n && (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        op       = CUR_NONE;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(in_char)) begin
                        op = CUR_ADV;
                    end else begin
                        case (in_char)
                            `DP_CHAR_CR: op = CUR_CR;
                            `DP_CHAR_LF: op = CUR_LF;
                            `DP_CHAR_BS: op = CUR_BS;
                            `DP_CHAR_FF: state_nx = ST_CLEAR;
                            default: ;
                        endcase
                    end
                    if (scroll_req) state_nx = ST_SCROLL;
                end
            end
            ST_SCROLL: if (filling && cnt_x == X_LAST) state_nx = ST_IDLE;
            ST_CLEAR: begin
                if (cnt_x == X_LAST && cnt_y == Y_LAST) begin
                    state_nx = ST_IDLE;
                    op       = CUR_HOME;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            wr_en_q <= 1'b0;
            cp_vld  <= 1'b0;
            filling <= 1'b0;
            cnt_x   <= '0;
            cnt_y   <= '0;
        end else begin
            state   <= state_nx;
            wr_en_q <= 1'b0;
            cp_vld  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    filling <= 1'b0;
                    cnt_x   <= '0;
                    // Scroll reads start at row 1; clear starts at row 0.
                    cnt_y   <= (state_nx == ST_SCROLL) ? YW'(1) : '0;
                    if (accept && (is_printable(in_char) ||
                                   (in_char == `DP_CHAR_BS && cur_x != '0)))
                        wr_en_q <= 1'b1;
                end
                ST_SCROLL: begin
                    if (!filling) begin
                        cp_vld <= 1'b1;
                        if (cnt_x == X_LAST) begin
                            cnt_x <= '0;
                            if (cnt_y == Y_LAST) filling <= 1'b1;
                            else                 cnt_y   <= cnt_y + 1'b1;
                        end else begin
                            cnt_x <= cnt_x + 1'b1;
                        end
                    end else begin
                        wr_en_q <= 1'b1;
                        cnt_x   <= cnt_x + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    wr_en_q <= 1'b1;
                    if (cnt_x == X_LAST) begin
                        cnt_x <= '0;
                        cnt_y <= cnt_y + 1'b1;
                    end else begin
                        cnt_x <= cnt_x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) attr_q <= in_attr;
        cp_x <= cnt_x;
        cp_y <= cnt_y - 1'b1;
        if (state == ST_IDLE) begin
            wr_y_q <= cur_y;
            if (in_char == `DP_CHAR_BS) begin
                wr_x_q    <= cur_x - 1'b1;
                wr_data_q <= {in_attr, SPACE};
            end else begin
                wr_x_q    <= cur_x;
                wr_data_q <= {in_attr, in_char};
            end
        end else begin
            wr_x_q    <= cnt_x;
            wr_y_q    <= cnt_y;
            wr_data_q <= {attr_q, SPACE};
        end
    end

    // Copy writes land the cycle after their read, carrying rd_data straight through.
    assign wr_en   = wr_en_q | cp_vld;
    assign wr_x    = cp_vld ? cp_x : wr_x_q;
    assign wr_y    = cp_vld ? cp_y : wr_y_q;
    assign wr_data = cp_vld ? rd_data : wr_data_q;
    assign rd_x    = cnt_x;
    assign rd_y    = cnt_y;

    always_comb begin
        ctrl_reg        = '0;
        ctrl_reg[7:0]   = 8'(cur_x);
        ctrl_reg[12:8]  = 5'(cur_y);
    end

endmodule

// File: tb/tb_console_writer.sv
// Directed bench for console_writer with a behavioural 80x30 text buffer.
module tb_console_writer;
    logic                        clk = 1'b0;
    logic                        reset_n = 1'b0;
    logic [7:0]                  in_char = 8'h00;
    logic [7:0]                  in_attr = 8'h00;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    logic                        wr_en;
    logic [`DP_X_ADDR_WIDTH-1:0] wr_x;
    logic [`DP_Y_ADDR_WIDTH-1:0] wr_y;
    logic [15:0]                 wr_data;
    logic [`DP_X_ADDR_WIDTH-1:0] rd_x;
    logic [`DP_Y_ADDR_WIDTH-1:0] rd_y;
    logic [15:0]                 rd_data = 16'h0000;
    logic [`DP_REG_WIDTH-1:0]    ctrl_reg;

    logic [15:0] mem [0:29][0:79];
    int n_checks = 0;
    int n_fails  = 0;

    console_writer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_char  (in_char),
        .in_attr  (in_attr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_data  (wr_data),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_data  (rd_data),
        .ctrl_reg (ctrl_reg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en && wr_x < 80 && wr_y < 30) mem[wr_y][wr_x] <= wr_data;
        rd_data <= (rd_x < 80 && rd_y < 30) ? mem[rd_y][rd_x] : 16'h0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one byte at a negedge; returns at the following negedge with the
    // byte accepted and its registered effects visible.
    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int guard;
        guard = 0;
        while (!in_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
        in_char  = c;
        in_attr  = a;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc, writes, bad;
        for (int yy = 0; yy < 30; yy++)
            for (int xx = 0; xx < 80; xx++)
                mem[yy][xx] = 16'h0000;

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(in_ready), 32'd0);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_ctrl", 32'(ctrl_reg), 32'h0000);
        reset_n = 1'b1;
        #1;
        check("post_reset_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        send(8'h41, 8'h07);
        check("A_wr_en", 32'(wr_en), 32'd1);
        check("A_addr", {wr_y, wr_x}, 32'h0000);
        check("A_data", 32'(wr_data), 32'h0741);
        check("A_ctrl", 32'(ctrl_reg), 32'h0001);

        for (int i = 1; i < 80; i++) begin
            send(8'h42, 8'h07);
            check("row0_wr", {31'(wr_x), wr_en}, {31'(i), 1'b1});
        end
        check("row0_last_y", 32'(wr_y), 32'd0);
        check("row0_ctrl", 32'(ctrl_reg), 32'h0100);

        send(8'h0A, 8'h07);
        check("lf_no_write", 32'(wr_en), 32'd0);
        send(8'h0A, 8'h07);
        check("lf_ctrl", 32'(ctrl_reg), 32'h0300);
        send(8'h08, 8'h07);
        check("bs0_no_write", 32'(wr_en), 32'd0);
        check("bs0_ctrl", 32'(ctrl_reg), 32'h0300);
        send(8'h61, 8'h07);
        send(8'h62, 8'h07);
        send(8'h63, 8'h07);
        send(8'h64, 8'h07);
        check("abcd_ctrl", 32'(ctrl_reg), 32'h0304);
        send(8'h08, 8'h07);
        check("bs_wr_en", 32'(wr_en), 32'd1);
        check("bs_addr", {24'(wr_y), 8'(wr_x)}, 32'h0303);
        check("bs_data", 32'(wr_data), 32'h0720);
        check("bs_ctrl", 32'(ctrl_reg), 32'h0303);
        send(8'h0D, 8'h07);
        check("cr_no_write", 32'(wr_en), 32'd0);
        check("cr_ctrl", 32'(ctrl_reg), 32'h0300);
        send(8'h01, 8'h07);
        check("other_no_write", 32'(wr_en), 32'd0);
        check("other_ctrl", 32'(ctrl_reg), 32'h0300);

        for (int i = 0; i < 26; i++) send(8'h0A, 8'h07);
        check("row29_ctrl", 32'(ctrl_reg), 32'h1D00);
        for (int i = 0; i < 5; i++) send(8'h78, 8'h07);
        check("pre_scroll_ctrl", 32'(ctrl_reg), 32'h1D05);
        @(negedge clk);
        mem[1][3] = 16'h4E4D;

        send(8'h0A, 8'h17);
        check("scroll_ready_low", 32'(in_ready), 32'd0);
        check("scroll_ctrl", 32'(ctrl_reg), 32'h1D00);
        cyc = 0;
        while (!in_ready && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
        check("scroll_bounded", 32'(cyc <= 2402), 32'd1);
        check("scroll_min_len", 32'(cyc >= 2320), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("scroll_marked", 32'(mem[0][3]), 32'h4E4D);
        check("scroll_row2_a", 32'(mem[2][0]), 32'h0761);
        check("scroll_row2_bs", 32'(mem[2][3]), 32'h0720);
        check("scroll_row28_x", 32'(mem[28][4]), 32'h0778);
        bad = 0;
        for (int xx = 0; xx < 80; xx++)
            if (mem[29][xx] !== 16'h1720) bad++;
        check("scroll_row29_spaces", 32'(bad), 32'd0);
        check("scroll_end_ctrl", 32'(ctrl_reg), 32'h1D00);

        send(8'h0C, 8'h1F);
        writes = 0;
        bad    = 0;
        cyc    = 0;
        while (cyc < 3000) begin
            if (wr_en) begin
                writes++;
                if (wr_data !== 16'h1F20) bad++;
            end
            if (in_ready) break;
            cyc++;
            @(negedge clk);
        end
        check("clear_writes", 32'(writes), 32'd2400);
        check("clear_bad_data", 32'(bad), 32'd0);
        check("clear_ctrl", 32'(ctrl_reg), 32'h0000);
        @(negedge clk);
        check("clear_last_cell", 32'(mem[29][79]), 32'h1F20);

        send(8'h5A, 8'h07);
        check("z_ctrl", 32'(ctrl_reg), 32'h0001);
        send(8'h0C, 8'h1F);
        repeat (100) @(negedge clk);
        check("clear_midway_wr", 32'(wr_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_wr_en", 32'(wr_en), 32'd0);
        check("abort_ctrl", 32'(ctrl_reg), 32'h0000);
        check("abort_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("abort_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        send(8'h51, 8'h07);
        check("q_addr", {wr_y, wr_x}, 32'h0000);
        check("q_data", 32'(wr_data), 32'h0751);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows per screen.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_char, input, 8, the ASCII byte offered.
REQ-006 SHALL have port in_attr, input, 8, colour attribute {bg[3:0], fg[3:0]}, sampled with in_char.
REQ-007 SHALL have port in_valid, input, 1, meaning in_char/in_attr are valid.
REQ-008 SHALL have port in_ready, output, 1; a byte is accepted on a cycle with in_valid && in_ready.
REQ-009 SHALL have port wr_en, output, 1, the text-buffer write strobe.
REQ-010 SHALL have port wr_x, output, `DP_X_ADDR_WIDTH, the write column.
REQ-011 SHALL have port wr_y, output, `DP_Y_ADDR_WIDTH, the write row.
REQ-012 SHALL have port wr_data, output, 16, the cell {bg, fg, ascii}.
REQ-013 SHALL have port rd_x, output, `DP_X_ADDR_WIDTH, the read column.
REQ-014 SHALL have port rd_y, output, `DP_Y_ADDR_WIDTH, the read row.
REQ-015 SHALL have port rd_data, input, 16; valid exactly one cycle after rd_x/rd_y are presented.
REQ-016 SHALL have port ctrl_reg, output, `DP_REG_WIDTH; [7:0] = cursor x, [12:8] = cursor y, all other bits 0.

Function
REQ-017 SHALL implement states IDLE, SCROLL, CLEAR; in_ready SHALL be 1 only in IDLE.
REQ-018 Printable bytes 0x20-0x7E SHALL produce a single registered wr_en pulse in the cycle after acceptance: address = cursor before the byte, data = {in_attr, in_char}; cursor x then increments.
REQ-019 Printable written at x = COLS-1 SHALL set x = 0 and y = y+1.
REQ-020 0x0D (CR) SHALL set x = 0 with no write.
REQ-021 0x0A (LF) SHALL set x = 0 and y = y+1 with no write.
REQ-022 0x08 (BS) at x > 0 SHALL set x = x-1 and write {in_attr, 0x20} at the new position; at x = 0 it SHALL do nothing.
REQ-023 0x0C (FF) SHALL enter CLEAR and write {in_attr, 0x20} to every cell, row-major from (0,0), one cell per cycle (COLS*ROWS cycles); it SHALL then set the cursor to (0,0) and return to IDLE.
REQ-024 Every other byte SHALL be consumed with no write and no cursor change.
REQ-025 When a y increment would reach ROWS, the cursor SHALL be (0, ROWS-1) and the block SHALL enter SCROLL.
REQ-026 SCROLL SHALL copy every cell (x, y) for y = 1..ROWS-1 to (x, y-1) as a pipeline: read issued in cycle k, write in cycle k+1.
REQ-027 SCROLL SHALL then fill row ROWS-1 with {last accepted attr, 0x20} and return to IDLE; total duration SHALL be at most (ROWS-1)*COLS + COLS + 2 cycles.
REQ-028 A back-to-back printable stream SHALL sustain one byte per cycle in IDLE.
REQ-029 ctrl_reg SHALL be registered and change in the cycle a cursor update takes effect.
REQ-030 wr_x/wr_y/wr_data SHALL be don't-care when wr_en = 0; rd_x/rd_y SHALL be don't-care outside SCROLL.

Reset
REQ-031 reset_n low SHALL force: state IDLE, cursor (0,0), ctrl_reg 0, wr_en 0, in_ready 0 while reset_n is asserted.
REQ-032 in_ready SHALL go to 1 in the first cycle after reset_n deasserts.
REQ-033 Reset during SCROLL or CLEAR SHALL abort the operation immediately; buffer contents are then undefined.

Structure
REQ-034 COLS/ROWS defaults and the control codes (0x08, 0x0A, 0x0C, 0x0D) SHALL live in the shared display defines header, alongside the existing DP_* widths.
REQ-035 Cursor arithmetic (advance, wrap, scroll request) SHALL be one sub-module, console_cursor; the FSM and copy/fill counters remain in console_writer.

Verification
REQ-036 Reset, then 'A' with attr 0x07 -> wr_en at (0,0) with data 0x0741; ctrl_reg = 0x0001.
REQ-037 80 printables on row 0 -> the last is written at (79,0); ctrl_reg = 0x0100.
REQ-038 Cursor at (5,29), send LF -> SCROLL; a marked cell at (3,1) appears at (3,0); row 29 is spaces; in_ready is low throughout; cursor ends at (0,29); duration ≤ 2402 cycles.
REQ-039 BS at (0,3) -> no write and no cursor change; BS at (4,3) -> write 0x20 at (3,3); cursor = (3,3).
REQ-040 FF with attr 0x1F -> 2400 writes of 0x1F20; cursor ends at (0,0); assert reset_n midway -> wr_en drops immediately and ctrl_reg = 0.
